// File: rtl/morse_key_decoder.sv
// morse_key_decoder: input front end of the Morse decoder.
// Synchronizes and debounces the raw key, times each press as a dot or a
// dash, collects up to five symbols and, after an inter-letter gap, emits
// the decoded letter (0 = A .. 25 = Z, 31 = blank/invalid) with a
// one-cycle strobe.
module morse_key_decoder #(
  parameter int TICK_DIV         = 100000,
  parameter int DEBOUNCE_TICKS   = 10,
  parameter int DOT_MAX_TICKS    = 200,
  parameter int LETTER_GAP_TICKS = 600
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       key_in,
  output logic [4:0] LETTER,
  output logic       letter_valid,
  output logic [2:0] sym_count,
  output logic       key_db
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int DUR_MAX = (DOT_MAX_TICKS > LETTER_GAP_TICKS) ? DOT_MAX_TICKS : LETTER_GAP_TICKS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LIMIT  = DB_W'(DEBOUNCE_TICKS);
  localparam logic [DUR_W-1:0] DOT_LIMIT = DUR_W'(DOT_MAX_TICKS);
  localparam logic [DUR_W-1:0] GAP_LIMIT = DUR_W'(LETTER_GAP_TICKS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;

  logic [1:0]       sync_q, sync_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             tick;
  logic [DB_W-1:0]  dbCnt_q, dbCnt_d;
  logic             keyDb_q, keyDb_d;
  logic [1:0]       state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [3:0]       symBits_q, symBits_d;
  logic [2:0]       symCount_q, symCount_d;
  logic [4:0]       letter_q, letter_d;

  // Translates symbol count plus collected bits (first symbol highest, dash = 1)
  // into a letter index; anything unassigned or overflowed decodes to blank.
  function automatic logic [4:0] lookup(input logic [2:0] n, input logic [3:0] b);
    logic [4:0] r;
    r = 5'd31;
    case ({n, b})
      7'b001_0000: r = 5'd4;
      7'b001_0001: r = 5'd19;
      7'b010_0000: r = 5'd8;
      7'b010_0001: r = 5'd0;
      7'b010_0010: r = 5'd13;
      7'b010_0011: r = 5'd12;
      7'b011_0000: r = 5'd18;
      7'b011_0001: r = 5'd20;
      7'b011_0010: r = 5'd17;
      7'b011_0011: r = 5'd22;
      7'b011_0100: r = 5'd3;
      7'b011_0101: r = 5'd10;
      7'b011_0110: r = 5'd6;
      7'b011_0111: r = 5'd14;
      7'b100_0000: r = 5'd7;
      7'b100_0001: r = 5'd21;
      7'b100_0010: r = 5'd5;
      7'b100_0100: r = 5'd11;
      7'b100_0110: r = 5'd15;
      7'b100_0111: r = 5'd9;
      7'b100_1000: r = 5'd1;
      7'b100_1001: r = 5'd23;
      7'b100_1010: r = 5'd2;
      7'b100_1011: r = 5'd24;
      7'b100_1100: r = 5'd25;
      7'b100_1101: r = 5'd16;
      default:     r = 5'd31;
    endcase
    return r;
  endfunction

  assign tick = (divCnt_q == DIV_LAST);

  // Next state for the synchronizer, the tick divider and the debouncer.
  always_comb begin
    sync_d   = {sync_q[0], key_in};
    divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
    dbCnt_d  = dbCnt_q;
    keyDb_d  = keyDb_q;
    if (sync_q[1] == keyDb_q) begin
      dbCnt_d = '0;
    end else if (dbCnt_q == DB_LIMIT) begin
      keyDb_d = ~keyDb_q;
      dbCnt_d = '0;
    end else if (tick) begin
      dbCnt_d = dbCnt_q + DB_W'(1);
    end
  end

  // Registers the front end: synchronizer, divider and debounced key level.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      divCnt_q <= '0;
      dbCnt_q  <= '0;
      keyDb_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      divCnt_q <= divCnt_d;
      dbCnt_q  <= dbCnt_d;
      keyDb_q  <= keyDb_d;
    end
  end

  // Press/gap timing, symbol collection and letter decode at the gap.
  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    symBits_d  = symBits_q;
    symCount_d = symCount_q;
    letter_d   = letter_q;
    case (state_q)
      IDLE: begin
        dur_d = '0;
        if (keyDb_q) state_d = PRESS;
      end
      PRESS: begin
        if (!keyDb_q) begin
          if (symCount_q < 3'd4) symBits_d = {symBits_q[2:0], (dur_q >= DOT_LIMIT)};
          if (symCount_q < 3'd5) symCount_d = symCount_q + 3'd1;
          dur_d   = '0;
          state_d = GAP;
        end else if (tick && (dur_q < DOT_LIMIT)) begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      GAP: begin
        if (dur_q == GAP_LIMIT) begin
          letter_d   = lookup(symCount_q, symBits_q);
          symBits_d  = '0;
          symCount_d = '0;
          dur_d      = '0;
          state_d    = EMIT;
        end else if (keyDb_q) begin
          dur_d   = '0;
          state_d = PRESS;
        end else if (tick) begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      EMIT: begin
        dur_d   = '0;
        state_d = IDLE;
      end
      default: begin
        dur_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Registers the decoder state; the letter register holds until the next strobe.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dur_q      <= '0;
      symBits_q  <= '0;
      symCount_q <= '0;
      letter_q   <= 5'd31;
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      symBits_q  <= symBits_d;
      symCount_q <= symCount_d;
      letter_q   <= letter_d;
    end
  end

  assign LETTER       = letter_q;
  assign letter_valid = (state_q == EMIT);
  assign sym_count    = symCount_q;
  assign key_db       = keyDb_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: directed and randomized key sequences for the Morse
// key decoder. Key activity is described in ticks; the reference model turns
// each press duration into a dot or dash and looks the resulting string up in
// an International Morse table.
module tb_morse_key_decoder;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 2;
  localparam int DOT_MAX  = 10;
  localparam int GAP      = 20;

  logic       board_clk = 1'b0;
  logic       reset;
  logic       key_in;
  logic [4:0] LETTER;
  logic       letter_valid;
  logic [2:0] sym_count;
  logic       key_db;

  int         checks = 0;
  int         failures = 0;
  int         strobeCount = 0;
  int         longStrobes = 0;
  logic [4:0] lastLetter = 5'd31;
  logic       prevValid = 1'b0;
  string      modelSyms = "";

  string morseTable [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                             "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                             "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                             "-.--", "--.."};

  morse_key_decoder #(
    .TICK_DIV(TICK_DIV),
    .DEBOUNCE_TICKS(DEB),
    .DOT_MAX_TICKS(DOT_MAX),
    .LETTER_GAP_TICKS(GAP)
  ) dut (
    .board_clk(board_clk),
    .reset(reset),
    .key_in(key_in),
    .LETTER(LETTER),
    .letter_valid(letter_valid),
    .sym_count(sym_count),
    .key_db(key_db)
  );

  // Free-running 100 MHz board clock.
  always #5 board_clk = ~board_clk;

  // Watches the strobe away from the active edge: counts strobes, keeps the
  // last letter and notes any strobe lasting more than one cycle.
  always @(negedge board_clk) begin
    if (letter_valid === 1'b1) begin
      strobeCount = strobeCount + 1;
      lastLetter  = LETTER;
      if (prevValid === 1'b1) longStrobes = longStrobes + 1;
    end
    prevValid = letter_valid;
  end

  function automatic int expectLetter(input string syms);
    if (syms.len() == 0 || syms.len() > 4) return 31;
    for (int i = 0; i < 26; i++) begin
      if (morseTable[i] == syms) return i;
    end
    return 31;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      failures = failures + 1;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic releaseKey(input int ticks);
    key_in = 1'b0;
    repeat (ticks * TICK_DIV) @(negedge board_clk);
  endtask

  task automatic pressKey(input int ticks);
    key_in = 1'b1;
    repeat (ticks * TICK_DIV) @(negedge board_clk);
    key_in = 1'b0;
    if (ticks < DOT_MAX) modelSyms = {modelSyms, "."};
    else modelSyms = {modelSyms, "-"};
  endtask

  task automatic applyStimulus(input string code, input int dotT, input int dashT,
                               input int gapT, input int endT);
    byte c;
    for (int i = 0; i < code.len(); i++) begin
      c = code[i];
      if (c == "-") pressKey(dashT);
      else pressKey(dotT);
      if (i < code.len() - 1) releaseKey(gapT);
    end
    releaseKey(endT);
  endtask

  task automatic letterCheck(input string tag, input int strobesBefore);
    int expLetter;
    expLetter = expectLetter(modelSyms);
    checkOutput({tag, "_strobes"}, strobeCount, strobesBefore + 1);
    checkOutput({tag, "_letter"}, lastLetter, expLetter);
    checkOutput({tag, "_symcount"}, sym_count, 0);
    modelSyms = "";
  endtask

  initial begin
    int base;
    int idx;
    reset  = 1'b1;
    key_in = 1'b0;
    repeat (3) @(negedge board_clk);
    checkOutput("rst_letter", LETTER, 31);
    checkOutput("rst_valid", letter_valid, 0);
    checkOutput("rst_symcount", sym_count, 0);
    checkOutput("rst_keydb", key_db, 0);
    reset = 1'b0;
    repeat (2) @(negedge board_clk);

    $display("[TB] dot then dash");
    base = strobeCount;
    pressKey(5); releaseKey(5); pressKey(15); releaseKey(30);
    letterCheck("t1_A", base);
    checkOutput("t1_A_const", lastLetter, 0);
    base = strobeCount;
    pressKey(4); releaseKey(30);
    letterCheck("t1_E", base);
    checkOutput("t1_E_const", lastLetter, 4);

    $display("[TB] dot/dash boundary");
    base = strobeCount;
    pressKey(DOT_MAX - 1); releaseKey(30);
    letterCheck("t2_dur9", base);
    checkOutput("t2_dur9_const", lastLetter, 4);
    base = strobeCount;
    pressKey(DOT_MAX); releaseKey(30);
    letterCheck("t2_dur10", base);
    checkOutput("t2_dur10_const", lastLetter, 19);

    $display("[TB] bounce");
    base = strobeCount;
    key_in = 1'b0;
    for (int i = 0; i < 14; i++) begin
      key_in = ~key_in;
      repeat (3) @(negedge board_clk);
      checkOutput("t3_keydb_bounce", key_db, 0);
    end
    releaseKey(30);
    checkOutput("t3_keydb_after", key_db, 0);
    checkOutput("t3_no_strobe", strobeCount, base);

    $display("[TB] overflow and invalid code");
    base = strobeCount;
    for (int i = 0; i < 5; i++) begin
      pressKey(4);
      releaseKey(5);
    end
    checkOutput("t4_symcount5", sym_count, 5);
    releaseKey(25);
    letterCheck("t4_overflow", base);
    checkOutput("t4_overflow_const", lastLetter, 31);
    base = strobeCount;
    applyStimulus("----", 4, 14, 5, 30);
    letterCheck("t4_dashx4", base);
    checkOutput("t4_dashx4_const", lastLetter, 31);

    $display("[TB] full table");
    base = strobeCount;
    for (int i = 0; i < 26; i++) begin
      applyStimulus(morseTable[i], 4, 14, 5, 30);
      letterCheck("t5_table", base + i);
      checkOutput("t5_table_const", lastLetter, i);
    end
    checkOutput("t5_total_strobes", strobeCount, base + 26);

    $display("[TB] reset mid-letter");
    base = strobeCount;
    pressKey(14); releaseKey(5);
    key_in = 1'b1;
    repeat (5 * TICK_DIV) @(negedge board_clk);
    reset  = 1'b1;
    key_in = 1'b0;
    repeat (3) @(negedge board_clk);
    reset = 1'b0;
    modelSyms = "";
    checkOutput("t6_rst_letter", LETTER, 31);
    checkOutput("t6_rst_symcount", sym_count, 0);
    checkOutput("t6_rst_keydb", key_db, 0);
    releaseKey(10);
    checkOutput("t6_no_strobe", strobeCount, base);
    pressKey(4); releaseKey(5); pressKey(14); releaseKey(10);
    checkOutput("t6_hold31", LETTER, 31);
    checkOutput("t6_no_strobe_yet", strobeCount, base);
    releaseKey(25);
    letterCheck("t6_A", base);
    checkOutput("t6_A_const", lastLetter, 0);

    $display("[TB] randomized letters");
    for (int n = 0; n < 20; n++) begin
      idx  = $urandom_range(0, 25);
      base = strobeCount;
      applyStimulus(morseTable[idx], $urandom_range(4, 7), $urandom_range(12, 18),
                    $urandom_range(4, 10), $urandom_range(26, 36));
      letterCheck("t7_random", base);
      checkOutput("t7_random_idx", lastLetter, idx);
    end

    checkOutput("one_cycle_strobes", longStrobes, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Input-side front end of the Morse decoder: samples the raw Morse key, debounces it, classifies each press as dot or dash by duration, and collects symbols until an inter-letter gap. At the gap it emits the decoded letter on the 5-bit `LETTER` bus that the VGA display stage consumes, with a one-cycle strobe. It is the producer end of the `LETTER` interface.

## Interface
- `TICK_DIV`, 100000: board_clk cycles per timing tick (1 ms at 100 MHz).
- `DEBOUNCE_TICKS`, 10: consecutive stable ticks required to accept a key level change.
- `DOT_MAX_TICKS`, 200: a press shorter than this is a dot; a press of this length or longer is a dash.
- `LETTER_GAP_TICKS`, 600: release duration that terminates a letter.
- `board_clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `key_in`  in  1  raw key, active-high (pressed = 1), asynchronous to board_clk.
- `LETTER`  out  5  last decoded letter, 0 = A … 25 = Z, 31 = blank/invalid; held between updates.
- `letter_valid`  out  1  one-cycle strobe; `LETTER` is updated on the same edge.
- `sym_count`  out  3  symbols collected for the current letter, 0–5 (5 = overflow).
- `key_db`  out  1  debounced key level, for an LED.

## Operation
- Two-flop synchronizer on `key_in`, then the debouncer. `tick` is a 1-cycle pulse every `TICK_DIV` cycles from a free-running counter that wraps at `TICK_DIV-1`.
- Debouncer:
  - A stable counter increments on `tick` while the synced level differs from `key_db`, and clears when they are equal.
  - When the counter reaches `DEBOUNCE_TICKS`, `key_db` toggles and the counter clears.
- Symbol register `sym_bits[3:0]`: shift-in from the LSB; dot = 0, dash = 1. After n symbols, the first symbol sits at bit n-1.
- FSM states: IDLE, PRESS, GAP, EMIT.
  - IDLE: `dur` = 0. On the `key_db` rise, go to PRESS.
  - PRESS: `dur` increments on `tick` and saturates at `DOT_MAX_TICKS`. On the `key_db` fall:
    - classify as dot if `dur < DOT_MAX_TICKS`, else dash;
    - if `sym_count < 4`, shift the symbol in, otherwise do not shift;
    - `sym_count` = min(`sym_count`+1, 5);
    - clear `dur` and go to GAP.
  - GAP: `dur` increments on `tick`.
    - `key_db` rise before the threshold: clear `dur`, go to PRESS (same letter).
    - `dur` == `LETTER_GAP_TICKS`: go to EMIT.
  - EMIT (one cycle):
    - `LETTER` = lookup(`sym_count`, `sym_bits`) and `letter_valid` = 1;
    - clear `sym_bits` and `sym_count`, go to IDLE.
- Lookup uses International Morse for A–Z and must be exact for all 26 letters. `LETTER` = 31 for:
  - `sym_count` = 5 (overflow);
  - the unassigned 4-symbol codes `..--`, `.-.-`, `---.` and `----`.
- A key rise in the EMIT cycle is seen in IDLE on the next cycle; no press is lost, because `key_db` is a level.

## Timing
- Reset values: `LETTER` = 31, `letter_valid` = 0, `sym_count` = 0, `key_db` = 0, FSM = IDLE, all counters 0.
- Reset mid-letter discards all collected symbols. No strobe is issued.
- Input-to-`key_db` latency: 2 cycles of sync, plus `DEBOUNCE_TICKS` ticks, plus 1 cycle.
- `letter_valid` rises on the board_clk edge after the tick on which the GAP `dur` reaches `LETTER_GAP_TICKS`. It is high for exactly 1 cycle. `LETTER` is stable from that edge until the next strobe.
- Key glitches shorter than `DEBOUNCE_TICKS` ticks produce no `key_db` change.
- Saturating counters never wrap. A press of any length is a dash; an idle period of any length produces no extra strobes, since IDLE does not count.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `DEBOUNCE_TICKS`=2, `DOT_MAX_TICKS`=10, `LETTER_GAP_TICKS`=20.

1. Dot then dash:
   - Stimulus: press 5 ticks, release 5, press 15, release 30.
   - Required: one strobe, `LETTER`=0 (A), `sym_count` returns to 0. Press 4 ticks then release 30 gives `LETTER`=4 (E).
2. Dot/dash boundary:
   - Stimulus: press lengths giving measured `dur` of 9 and 10 (each a separate letter).
   - Required: `LETTER`=4 (E) for 9, then `LETTER`=19 (T) for 10.
3. Bounce:
   - Stimulus: toggle `key_in` every 3 cycles for 40 cycles, then hold 0.
   - Required: `key_db` stays 0, no strobe.
4. Overflow and invalid code:
   - Stimulus: five dots, then the gap.
   - Required: `sym_count` reaches 5, `LETTER`=31.
   - Stimulus: `----` (four dashes).
   - Required: `LETTER`=31.
5. Full table: drive all 26 letter codes in sequence. Required: `LETTER` = 0..25 in order, exactly 26 one-cycle strobes.
6. Reset mid-letter:
   - Stimulus: assert `reset` during the second symbol of `-.` (N), then drive `.-`.
   - Required: no strobe for the aborted letter, next `LETTER`=0, `LETTER`=31 between reset and that strobe.
